sram_arbiter: RTL and testbench

//  Shares one asynchronous 32-bit SRAM between the instruction-fetch port and the data (MEM-stage) port of cpu_core.

---
 rtl/sram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 32-bit SRAM between the fetch
// and data ports, sequencing ce_n/oe_n/we_n/byte_en_n with fixed timing.
module sram_arbiter #(
   parameter int ADDR_W  = 20,
   parameter int RD_WAIT = 1,
   parameter int WR_WAIT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_ready,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic [3:0]        ram_byte_en_n,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [31:0]       ram_data
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      DONE
   } state_e;

   localparam logic [3:0] RD_LAST = 4'(RD_WAIT);
   localparam logic [3:0] WR_LAST = 4'(WR_WAIT);
   localparam logic       P_FETCH = 1'b0;
   localparam logic       P_DATA  = 1'b1;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              port_q;
   logic              last_q;
   logic              drive_q;
   logic [31:0]       wdata_q;
   logic [ADDR_W-1:0] addr_q;
   logic              ce_n_q;
   logic              oe_n_q;
   logic              we_n_q;
   logic [3:0]        be_n_q;
   logic              if_ready_q;
   logic              d_ready_q;
   logic [31:0]       if_rdata_q;
   logic [31:0]       d_rdata_q;

   logic              pick_d;
   logic [ADDR_W-1:0] addr_d;
   logic              unused_addr;

   // On a tie the port that did not win last time gets the bus.
   always_comb begin
      pick_d = d_req;
      if (if_req && d_req) begin
         pick_d = (last_q == P_FETCH);
      end
   end

   assign addr_d = pick_d ? d_addr[ADDR_W+1:2]
                          : if_addr[ADDR_W+1:2];

   assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                          d_addr[31:ADDR_W+2], d_addr[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         port_q     <= P_FETCH;
         last_q     <= P_FETCH;
         drive_q    <= 1'b0;
         wdata_q    <= '0;
         addr_q     <= '0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         be_n_q     <= 4'hF;
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (if_req || d_req) begin
                  port_q <= pick_d;
                  last_q <= pick_d;
                  addr_q <= addr_d;
                  cnt_q  <= '0;
                  ce_n_q <= 1'b0;
                  if (pick_d && d_we) begin
                     wdata_q <= d_wdata;
                     be_n_q  <= ~d_be;
                     drive_q <= 1'b1;
                     state_q <= WR_SETUP;
                  end else begin
                     oe_n_q  <= 1'b0;
                     be_n_q  <= 4'h0;
                     state_q <= RD;
                  end
               end
            end
            RD: begin
               if (cnt_q == RD_LAST) begin
                  if (port_q == P_DATA) begin
                     d_rdata_q <= ram_data;
                     d_ready_q <= 1'b1;
                  end else begin
                     if_rdata_q <= ram_data;
                     if_ready_q <= 1'b1;
                  end
                  ce_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  be_n_q  <= 4'hF;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            WR_SETUP: begin
               we_n_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= WR_PULSE;
            end
            WR_PULSE: begin
               if (cnt_q == WR_LAST) begin
                  we_n_q  <= 1'b1;
                  state_q <= WR_HOLD;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            WR_HOLD: begin
               ce_n_q    <= 1'b1;
               be_n_q    <= 4'hF;
               drive_q   <= 1'b0;
               d_ready_q <= 1'b1;
               state_q   <= DONE;
            end
            // DONE gives the bus a turnaround cycle and masks held requests.
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ram_data      = drive_q ? wdata_q : 32'hzzzz_zzzz;
   assign ram_ce_n      = ce_n_q;
   assign ram_oe_n      = oe_n_q;
   assign ram_we_n      = we_n_q;
   assign ram_byte_en_n = be_n_q;
   assign ram_addr      = addr_q;
   assign if_ready      = if_ready_q;
   assign d_ready       = d_ready_q;
   assign if_rdata      = if_rdata_q;
   assign d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: vector table, hand-written corner sequences and random
// traffic against a word-level memory model for sram_arbiter.
`timescale 1ns/1ps
module tb_sram_arbiter;

   localparam int          ADDR_W  = 20;
   localparam int          RD_WAIT = 1;
   localparam int          WR_WAIT = 1;
   localparam int          RD_LAT  = RD_WAIT + 2;
   localparam int          WR_LAT  = WR_WAIT + 4;
   localparam logic [31:0] PROBE   = 32'h5A5A_A5A5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              if_req = 1'b0;
   logic [31:0]       if_addr = '0;
   logic [31:0]       if_rdata;
   logic              if_ready;
   logic              d_req = 1'b0;
   logic              d_we = 1'b0;
   logic [3:0]        d_be = '0;
   logic [31:0]       d_addr = '0;
   logic [31:0]       d_wdata = '0;
   logic [31:0]       d_rdata;
   logic              d_ready;
   logic              ram_ce_n;
   logic              ram_oe_n;
   logic              ram_we_n;
   logic [3:0]        ram_byte_en_n;
   logic [ADDR_W-1:0] ram_addr;
   wire  [31:0]       ram_data;

   int n_cmp = 0;
   int n_bad = 0;

   sram_arbiter #(
      .ADDR_W (ADDR_W),
      .RD_WAIT(RD_WAIT),
      .WR_WAIT(WR_WAIT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_rdata     (if_rdata),
      .if_ready     (if_ready),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_be         (d_be),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_ready      (d_ready),
      .ram_ce_n     (ram_ce_n),
      .ram_oe_n     (ram_oe_n),
      .ram_we_n     (ram_we_n),
      .ram_byte_en_n(ram_byte_en_n),
      .ram_addr     (ram_addr),
      .ram_data     (ram_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'h0051_0113;
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   // Asynchronous SRAM device; a probe value sits on the bus while ce_n is high
   logic [31:0] mem [256];
   bit          loaded;

   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
         loaded <= 1'b1;
      end else if (!ram_ce_n && !ram_we_n) begin
         for (int l = 0; l < 4; l++)
            if (!ram_byte_en_n[l])
               mem[ram_addr[7:0]][8*l +: 8] <= ram_data[8*l +: 8];
      end
   end

   assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]]
                   : (ram_ce_n ? PROBE : 32'hzzzz_zzzz);

   // Reference model: one word per address, byte-merge on write
   logic [31:0] ref_mem [256];
   logic [31:0] last_drd;

   task automatic ref_write(input int w, input logic [3:0] be,
                            input logic [31:0] d);
      for (int l = 0; l < 4; l++)
         if (be[l]) ref_mem[w][8*l +: 8] = d[8*l +: 8];
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic access(input bit dp, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
      int olow;
      int wlow;
      olow = 0;
      wlow = 0;
      if (dp) begin
         d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!ram_oe_n) olow++;
         if (!ram_we_n) wlow++;
         chk("oe_we_excl", 32'(!ram_oe_n && !ram_we_n), 32'd0);
         chk("stray_ready", 32'(dp ? if_ready : d_ready), 32'd0);
      end while (!(dp ? d_ready : if_ready) && lat < 40);
      if (dp && we) begin
         chk("we_width", 32'(wlow), 32'(WR_WAIT + 1));
         chk("oe_in_write", 32'(olow), 32'd0);
      end else begin
         chk("oe_width", 32'(olow), 32'(RD_WAIT + 1));
         chk("we_in_read", 32'(wlow), 32'd0);
      end
      rd = dp ? d_rdata : if_rdata;
      d_req = 1'b0;
      if_req = 1'b0;
      @(posedge clk); #1;
   endtask

   typedef struct {
      bit          dp;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      int          exp_lat;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [31:0] rd;
      int          lat;
      int          cyc;
      int          last_cyc;
      int          ngot;
      int          w;
      int          bw [4];

      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

      tbl[0]  = '{1'b1, 1'b1, 4'hF, 32'h8000_0100, 32'h1122_3344, 32'h0000_0000, WR_LAT};
      tbl[1]  = '{1'b1, 1'b0, 4'h0, 32'h8000_0100, 32'h0,         32'h1122_3344, RD_LAT};
      tbl[2]  = '{1'b1, 1'b1, 4'h4, 32'h8000_0102, 32'h00AB_0000, 32'h1122_3344, WR_LAT};
      tbl[3]  = '{1'b1, 1'b0, 4'h0, 32'h8000_0100, 32'h0,         32'h11AB_3344, RD_LAT};
      tbl[4]  = '{1'b1, 1'b1, 4'h0, 32'h8000_0100, 32'hFFFF_FFFF, 32'h11AB_3344, WR_LAT};
      tbl[5]  = '{1'b0, 1'b0, 4'h0, 32'h8000_0103, 32'h0,         32'h11AB_3344, RD_LAT};
      tbl[6]  = '{1'b1, 1'b1, 4'h9, 32'h8000_0104, 32'hA500_005A, 32'h11AB_3344, WR_LAT};
      tbl[7]  = '{1'b1, 1'b0, 4'h0, 32'h8000_0104, 32'h0,         32'hA5DE_005A, RD_LAT};
      tbl[8]  = '{1'b0, 1'b0, 4'h0, 32'h8000_0010, 32'h0,         32'h0051_0113, RD_LAT};
      tbl[9]  = '{1'b1, 1'b1, 4'h3, 32'h8000_0108, 32'h0000_BEEF, 32'hA5DE_005A, WR_LAT};
      tbl[10] = '{1'b0, 1'b0, 4'h0, 32'h8000_0108, 32'h0,         32'hC0DE_BEEF, RD_LAT};

      // Reset asserted while idle
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_ce_n", 32'(ram_ce_n), 32'd1);
      chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
      chk("rst_we_n", 32'(ram_we_n), 32'd1);
      chk("rst_ben", 32'(ram_byte_en_n), 32'hF);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_bus", ram_data, PROBE);
      chk("rst_if_rdy", 32'(if_ready), 32'd0);
      chk("rst_d_rdy", 32'(d_ready), 32'd0);
      chk("rst_if_rd", if_rdata, 32'd0);
      chk("rst_d_rd", d_rdata, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Vector table
      for (int i = 0; i < 11; i++) begin
         access(tbl[i].dp, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd,
                rd, lat);
         chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
         chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
         if (tbl[i].dp && tbl[i].we)
            ref_write(int'(tbl[i].addr[9:2]), tbl[i].be, tbl[i].wd);
      end

      // Single fetch, cycle by cycle
      if_req = 1'b1;
      if_addr = 32'h8000_0010;
      @(posedge clk); #1;
      chk("f_addr", 32'(ram_addr), 32'h0000_0004);
      chk("f_ce1", 32'(ram_ce_n), 32'd0);
      chk("f_oe1", 32'(ram_oe_n), 32'd0);
      chk("f_ben", 32'(ram_byte_en_n), 32'h0);
      chk("f_rdy1", 32'(if_ready), 32'd0);
      @(posedge clk); #1;
      chk("f_oe2", 32'(ram_oe_n), 32'd0);
      chk("f_rdy2", 32'(if_ready), 32'd0);
      @(posedge clk); #1;
      chk("f_rdy3", 32'(if_ready), 32'd1);
      chk("f_data", if_rdata, 32'h0051_0113);
      chk("f_ce3", 32'(ram_ce_n), 32'd1);
      if_req = 1'b0;
      @(posedge clk); #1;
      chk("f_rdy_pulse", 32'(if_ready), 32'd0);

      // Byte write, cycle by cycle
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0100;
      d_addr = 32'h8000_0142; d_wdata = 32'h00AB_0000;
      @(posedge clk); #1;
      chk("w_setup_ben", 32'(ram_byte_en_n), 32'hB);
      chk("w_setup_ce", 32'(ram_ce_n), 32'd0);
      chk("w_setup_we", 32'(ram_we_n), 32'd1);
      chk("w_setup_oe", 32'(ram_oe_n), 32'd1);
      chk("w_setup_addr", 32'(ram_addr), 32'h0000_0050);
      chk("w_setup_data", ram_data, 32'h00AB_0000);
      @(posedge clk); #1;
      chk("w_pulse1", 32'(ram_we_n), 32'd0);
      @(posedge clk); #1;
      chk("w_pulse2", 32'(ram_we_n), 32'd0);
      @(posedge clk); #1;
      chk("w_hold_we", 32'(ram_we_n), 32'd1);
      chk("w_hold_data", ram_data, 32'h00AB_0000);
      chk("w_hold_rdy", 32'(d_ready), 32'd0);
      @(posedge clk); #1;
      chk("w_done_rdy", 32'(d_ready), 32'd1);
      chk("w_done_ce", 32'(ram_ce_n), 32'd1);
      chk("w_done_bus", ram_data, PROBE);
      d_req = 1'b0;
      ref_write(32'h50, 4'b0100, 32'h00AB_0000);
      @(posedge clk); #1;
      access(1'b1, 1'b0, 4'h0, 32'h8000_0140, 32'h0, rd, lat);
      chk("w_readback", rd, 32'hC0AB_0050);

      // Contention after reset: data wins first, then strict alternation
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h8000_0010;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0100;
      ngot = 0; cyc = 0; last_cyc = 0;
      while (ngot < 6 && cyc < 80) begin
         @(posedge clk); #1;
         cyc++;
         chk("arb_both_rdy", 32'(if_ready && d_ready), 32'd0);
         if (if_ready || d_ready) begin
            chk("arb_order", 32'(d_ready), 32'((ngot % 2) == 0));
            chk("arb_gap", 32'(cyc - last_cyc),
                32'(ngot == 0 ? RD_WAIT + 2 : RD_WAIT + 3));
            if (d_ready) chk("arb_d_data", d_rdata, ref_mem[32'h40]);
            else chk("arb_if_data", if_rdata, ref_mem[4]);
            last_cyc = cyc;
            ngot++;
         end
      end
      chk("arb_count", 32'(ngot), 32'd6);
      if_req = 1'b0;
      d_req = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Reset during the write pulse
      d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
      d_addr = 32'h8000_0180; d_wdata = 32'hDEAD_BEEF;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end
      while (ram_we_n && cyc < 20);
      chk("rw_pulse_seen", 32'(ram_we_n), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rw_we_n", 32'(ram_we_n), 32'd1);
      chk("rw_ce_n", 32'(ram_ce_n), 32'd1);
      chk("rw_ben", 32'(ram_byte_en_n), 32'hF);
      chk("rw_bus", ram_data, PROBE);
      chk("rw_rdy0", 32'(d_ready), 32'd0);
      d_req = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("rw_rdy_rst", 32'(d_ready), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rw_rdy_after", 32'(d_ready), 32'd0);
      access(1'b1, 1'b1, 4'hF, 32'h8000_0180, 32'hDEAD_BEEF, rd, lat);
      chk("rw_redo_lat", 32'(lat), 32'(WR_LAT));
      ref_write(32'h60, 4'hF, 32'hDEAD_BEEF);
      access(1'b1, 1'b0, 4'h0, 32'h8000_0180, 32'h0, rd, lat);
      chk("rw_readback", rd, 32'hDEAD_BEEF);
      last_drd = rd;

      // Back-to-back fetches with if_req held
      bw = '{32'h40, 32'h41, 32'h42, 32'h50};
      if_req = 1'b1;
      if_addr = 32'h8000_0000 | (32'(bw[0]) << 2);
      ngot = 0; cyc = 0; last_cyc = 0;
      while (ngot < 4 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (if_ready) begin
            chk("b2b_data", if_rdata, ref_mem[bw[ngot]]);
            chk("b2b_gap", 32'(cyc - last_cyc),
                32'(ngot == 0 ? RD_WAIT + 2 : RD_WAIT + 3));
            last_cyc = cyc;
            ngot++;
            if (ngot < 4) if_addr = 32'h8000_0000 | (32'(bw[ngot]) << 2);
         end
      end
      if_req = 1'b0;
      chk("b2b_count", 32'(ngot), 32'd4);
      repeat (3) begin
         @(posedge clk); #1;
         chk("b2b_no_extra", 32'(if_ready), 32'd0);
      end

      // Random traffic against the reference model
      for (int k = 0; k < 150; k++) begin
         bit          dp;
         bit          we;
         logic [3:0]  be;
         logic [31:0] wd;
         logic [31:0] addr;
         dp = 1'($urandom_range(0, 1));
         we = dp && 1'($urandom_range(0, 1));
         be = 4'($urandom);
         wd = $urandom;
         w = int'($urandom_range(64, 127));
         addr = 32'h8000_0000 | (32'(w) << 2) | 32'($urandom_range(0, 3));
         access(dp, we, be, addr, wd, rd, lat);
         chk("rnd_lat", 32'(lat), 32'(we ? WR_LAT : RD_LAT));
         if (we) begin
            chk("rnd_d_hold", rd, last_drd);
            ref_write(w, be, wd);
         end else begin
            chk(dp ? "rnd_d_rd" : "rnd_if_rd", rd, ref_mem[w]);
            if (dp) last_drd = ref_mem[w];
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
